// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller: the default operand
// width and the controller state encoding.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Combinational 1-bit full adder; the single arithmetic cell shared by every
// bit position of the serial adder.
// Ports:
//   a, b, cin  - operand bits and carry-in
//   sum, cout  - sum bit and carry-out
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
// through a single fa_cell. IDLE accepts start, RUN processes WIDTH bits,
// DONE pulses done for one cycle and returns to IDLE.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, adds input 'sub'. sub=1 computes a + ~b + 1 (cin ignored),
//   so cout=1 means "no borrow".
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin an operation (only looked at in IDLE)
//   a, b   - operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   sub    - (SERIAL_ADDER_SUB_EN only) subtract select, captured with operands
//   busy   - high while in RUN
//   done   - one-cycle pulse while in DONE
//   sum    - result register
//   cout   - final carry-out register
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // Only WIDTH-1 bits are stored: the newest sum bit comes straight from the
  // cell, so the final result is {cell sum, psum_q}.
  logic [WIDTH-2:0]   psum_q, psum_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               fa_sum_s;
  logic               fa_cout_s;
  logic [WIDTH-1:0]   psum_full_s;
  logic [WIDTH-1:0]   b_in_s;
  logic               carry_in_s;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  assign psum_full_s = {fa_sum_s, psum_q};

  // Operand/carry selection at capture: subtraction is folded into the
  // loaded b (inverted) and carry (forced to 1).
  always_comb begin
    b_in_s     = b;
    carry_in_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_in_s     = ~b;
      carry_in_s = 1'b1;
    end else begin
      b_in_s     = b;
      carry_in_s = cin;
    end
`endif
  end

  // Next-state and datapath update for the serial adder controller.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b_in_s;
          carry_d = carry_in_s;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end

      RUN: begin
        psum_d  = psum_full_s[WIDTH-1:1];
        carry_d = fa_cout_s;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the result; counter is held so it never wraps.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = psum_full_s;
          cout_d  = fa_cout_s;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl (WIDTH=8). A cycle-level reference
// model tracks busy/done/sum/cout from plain arithmetic and a countdown;
// a negedge compare process checks the DUT against it every cycle, and
// directed scenarios add hand-computed literal expectations.
// Honors SERIAL_ADDER_SUB_EN for the optional subtract port.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {cout,sum} straight from the arithmetic definition.
  function automatic logic [W:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
`endif
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Reference model: an accepted op makes busy last W cycles, then done for
  // one cycle with the result; start is ignored outside idle.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic [W:0]   m_res  = '0;
  int           m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        {m_cout, m_sum} = m_res;
      end
    end else if (start) begin
      m_res  = ref_res(a, b, cin, sub);
      m_left = W;
      m_busy = 1'b1;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("sum",  sum,  m_sum);
    chk("cout", cout, m_cout);
  end

  // Run one operation; returns the result seen on done, and the number of
  // cycles from acceptance to done and of busy cycles.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input logic ts, output logic [W-1:0] rs, output logic rc,
                       output int lat, output int nbusy);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 1'b0, 1'b1);
    rs = sum; rc = cout;
  endtask

  logic [W-1:0] rs;
  logic         rc;
  int           lat, nbusy, pulses;
  logic [W:0]   exp;

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic add and latency
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, rs, rc, lat, nbusy);
    chk("lat_0f01", lat, 8);
    chk("busycyc_0f01", nbusy, 8);
    chk("sum_0f01", {rc, rs}, 9'h010);
    @(negedge clk);
    chk("done_pulse_len", done, 1'b0);

    do_op(8'hFF, 8'h01, 1'b0, 1'b0, rs, rc, lat, nbusy);
    chk("sum_ff01", {rc, rs}, 9'h100);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, rs, rc, lat, nbusy);
    chk("sum_ffff1", {rc, rs}, 9'h1FF);
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0, rs, rc, lat, nbusy);
    chk("sum_a55a1", {rc, rs}, 9'h100);

    // Start held high; operands changed mid-run
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF;
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("hold_sum", {cout, sum}, 9'h046);
    @(negedge clk);
    chk("hold_no_restart_in_done", busy, 1'b0);
    @(negedge clk);
    chk("hold_restart_idle", busy, 1'b1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("hold_second_sum", {cout, sum}, 9'h1FE);

    // Reset in the middle of RUN
    @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_sum", sum, 8'h00);
    a = 8'h03; b = 8'h04; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_accept", busy, 1'b1);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        chk("post_rst_sum", {cout, sum}, 9'h007);
      end
      @(negedge clk);
    end
    chk("post_rst_pulses", pulses, 1);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 1'b1, rs, rc, lat, nbusy);
    chk("sub_5_7", {rc, rs}, 9'h0FE);
    do_op(8'h07, 8'h05, 1'b0, 1'b1, rs, rc, lat, nbusy);
    chk("sub_7_5", {rc, rs}, 9'h102);
`endif

    // Random operand sets
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rcin, rsub;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rcin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      do_op(ra, rb, rcin, rsub, rs, rc, lat, nbusy);
      exp = ref_res(ra, rb, rcin, rsub);
      chk("rand_result", {rc, rs}, exp);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result bit width (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  first operand, captured on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  second operand, captured on the accepting edge.
REQ-007 SHALL have port cin  input  1  carry-in, captured on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse, high while in DONE.
REQ-010 SHALL have port sum  output  WIDTH  result register.
REQ-011 SHALL have port cout  output  1  final carry-out register.

Function
REQ-012 SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, through one 1-bit full-adder cell, one bit per clock.
REQ-013 SHALL implement a three-state FSM: IDLE -> RUN on start=1; RUN -> DONE on the edge processing bit WIDTH-1; DONE -> IDLE unconditionally.
REQ-014 On the accepting edge, SHALL load the a and b shift registers, load the carry flop with cin, and clear the bit counter to 0.
REQ-015 Each RUN edge SHALL shift the cell's sum bit into the partial-sum register MSB, store the cell's carry in the carry flop, shift a and b right, and increment the counter.
REQ-016 SHALL load sum and cout from the partial-sum register and the carry together, only on the RUN->DONE edge; they hold stable at all other times.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high between edge WIDTH and edge WIDTH+1.
REQ-018 SHALL ignore start in RUN and DONE: no restart, no operand recapture.
REQ-019 SHALL not accept start in DONE; back-to-back operations SHALL be accepted from IDLE, one cycle after done.
REQ-020 SHALL ignore changes on a, b and cin after the accepting edge.
REQ-021 The counter SHALL be $clog2(WIDTH) bits wide and SHALL not wrap within an operation.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0 and shift registers=0.
REQ-023 Reset during RUN SHALL abort the operation with no done pulse; the previous result is lost (sum=0).
REQ-024 SHALL accept the first start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN SHALL, when defined, add input port sub (1 bit, captured with the operands); sub=1 SHALL compute a + ~b + 1 (cin ignored) and cout=1 SHALL mean no borrow.
REQ-026 Without SERIAL_ADDER_SUB_EN, the port sub SHALL be absent and the block SHALL add only.

Structure
REQ-027 The shared package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 SHALL instantiate exactly one sub-module, fa_cell (combinational 1-bit full adder: a, b, cin -> sum, cout).

Verification
REQ-029 WIDTH=8, a=0x0F, b=0x01, cin=0, start pulse -> busy for 8 cycles, done at edge 8, sum=0x10, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 start held high through RUN and DONE, with a/b changed mid-run -> exactly one result from the captured operands; next accepted in IDLE one cycle after done.
REQ-032 rst_n pulsed low at RUN cycle 4 -> busy=0, done=0, sum=0 immediately; no done pulse follows.
REQ-033 With SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
REQ-034 Random test with 1000 operand sets -> {cout,sum} matches a + b + cin on every done pulse.
